// File: rtl/fft_pkg.sv
// Shared FFT definitions: point count and the input-buffer handshake state encodings.
package fft_pkg;
  localparam int N_POINTS = 8;
  localparam int IDX_W    = $clog2(N_POINTS);

  typedef enum logic {WR_FILL, WR_FULL_WAIT} wr_state_t;
  typedef enum logic {RD_EMPTY, RD_HOLD}     rd_state_t;
endpackage

// File: rtl/fft_input_buffer_if.sv
// Serial sample in / parallel frame out bus of the FFT input buffer.
interface fft_input_buffer_if #(parameter int DATA_W = 8);
  logic              in_valid;
  logic [DATA_W-1:0] in_data;
  logic              in_ready;
  logic [DATA_W-1:0] x0, x1, x2, x3, x4, x5, x6, x7;
  logic              frame_valid;
  logic              frame_ack;
  logic              overrun;

  // master: sample source plus FFT core; slave: the buffer itself
  modport master (output in_valid, in_data, frame_ack,
                  input  in_ready, x0, x1, x2, x3, x4, x5, x6, x7, frame_valid, overrun);
  modport slave  (input  in_valid, in_data, frame_ack,
                  output in_ready, x0, x1, x2, x3, x4, x5, x6, x7, frame_valid, overrun);
endinterface

// File: rtl/fft_sample_bank.sv
// N_POINTS x DATA_W register file: single write port, all words readable in parallel.
module fft_sample_bank
  import fft_pkg::*;
#(
  parameter int DATA_W = 8
) (
  input  logic                             fastclk,
  input  logic                             rst_n,
  input  logic                             we,
  input  logic [IDX_W-1:0]                 waddr,
  input  logic [DATA_W-1:0]                wdata,
  output logic [N_POINTS-1:0][DATA_W-1:0]  words
);
  always_ff @(posedge fastclk or negedge rst_n) begin
    if (!rst_n)  words        <= '0;
    else if (we) words[waddr] <= wdata;
  end
endmodule

// File: rtl/fft_input_buffer.sv
// Ping-pong serial-to-parallel buffer feeding the 8-point FFT core.
module fft_input_buffer
  import fft_pkg::*;
#(
  parameter int DATA_W = 8
) (
  input  logic               fastclk,
  input  logic               rst_n,
  fft_input_buffer_if.slave  bus
);
  wr_state_t wr_q, wr_d;
  rd_state_t rd_q, rd_d;
  logic [IDX_W-1:0] wr_idx;
  logic             bank_sel;   // index of the bank currently being written
  logic             overrun_q;
  logic             in_ready, accept, last, ack, swap;
  logic [1:0][N_POINTS-1:0][DATA_W-1:0] bank_words;
  logic [N_POINTS-1:0][DATA_W-1:0]      rd_words;

  assign in_ready = (wr_q == WR_FILL);
  assign accept   = bus.in_valid && in_ready;
  assign last     = accept && (wr_idx == IDX_W'(N_POINTS-1));
  assign ack      = bus.frame_ack && (rd_q == RD_HOLD);

  always_ff @(posedge fastclk or negedge rst_n) begin
    if (!rst_n) begin
      wr_q      <= WR_FILL;
      rd_q      <= RD_EMPTY;
      wr_idx    <= '0;
      bank_sel  <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      wr_q      <= wr_d;
      rd_q      <= rd_d;
      if (accept) wr_idx <= wr_idx + 1'b1;
      if (swap)   bank_sel <= ~bank_sel;
      if (bus.in_valid && !in_ready) overrun_q <= 1'b1;
    end
  end

  // A swap hands the just-completed write bank to the reader; the old read
  // bank is free by then, so writing can continue into it without a gap.
  always_comb begin
    wr_d = wr_q;
    rd_d = rd_q;
    swap = 1'b0;
    case (wr_q)
      WR_FILL: begin
        if (rd_q == RD_EMPTY) begin
          if (last) begin
            swap = 1'b1;
            rd_d = RD_HOLD;
          end
        end else begin
          if (last && ack)  swap = 1'b1;
          else if (last)    wr_d = WR_FULL_WAIT;
          else if (ack)     rd_d = RD_EMPTY;
        end
      end
      WR_FULL_WAIT: begin
        if (ack) begin
          swap = 1'b1;
          wr_d = WR_FILL;
        end
      end
      default: ;
    endcase
  end

  for (genvar b = 0; b < 2; b++) begin : g_bank
    fft_sample_bank #(.DATA_W(DATA_W)) u_bank (
      .fastclk (fastclk),
      .rst_n   (rst_n),
      .we      (accept && (bank_sel == 1'(b))),
      .waddr   (wr_idx),
      .wdata   (bus.in_data),
      .words   (bank_words[b])
    );
  end

  assign rd_words        = bank_words[~bank_sel];
  assign bus.x0          = rd_words[0];
  assign bus.x1          = rd_words[1];
  assign bus.x2          = rd_words[2];
  assign bus.x3          = rd_words[3];
  assign bus.x4          = rd_words[4];
  assign bus.x5          = rd_words[5];
  assign bus.x6          = rd_words[6];
  assign bus.x7          = rd_words[7];
  assign bus.in_ready    = in_ready;
  assign bus.frame_valid = (rd_q == RD_HOLD);
  assign bus.overrun     = overrun_q;
endmodule
